// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states,
// segment bit positions and the active-low nibble-to-segment table.
package seg_scan_ctrl_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-low {g,f,e,d,c,b,a}; a cleared bit lights the segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp_on);
        logic [7:0] code;
        code                = 8'hFF;
        code[SEG_G:SEG_A]   = SEG_TABLE[nibble];
        code[SEG_DP]        = ~dp_on;
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_nibble_enc.sv
// Combinational encoder for one display digit: hex nibble plus decimal point
// to the active-low {dp,g,f,e,d,c,b,a} byte shifted into the display chain.
module seg7_nibble_enc
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp_on,
    output logic [7:0] seg
);

    assign seg = seg_encode(nibble, dp_on);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Periodically snapshots one of four sources, encodes it as eight hex digits
// and shifts the 64-bit pattern MSB-first into an external display shift chain.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int REFRESH_CYCLES = 65536,
    parameter int DWELL_FRAMES   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC-1:0][31:0] src_data,
    input  logic                    manual,
    input  logic [1:0]              sel_idx,
    output logic                    s_clk,
    output logic                    s_clrn,
    output logic                    sout,
    output logic                    seg_en,
    output logic [1:0]              cur_idx,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int FW = $clog2(DWELL_FRAMES + 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [7:0]    DIV_LAST     = 8'(CLK_DIV - 1);
    localparam logic [FW-1:0] DWELL_LAST   = FW'(DWELL_FRAMES);

    scan_state_t     state, state_next;
    logic [RW-1:0]   refresh_cnt;
    logic            tick;
    logic [FW-1:0]   frame_cnt, frame_cnt_next, frame_cnt_inc;
    logic [1:0]      auto_idx, auto_idx_next, adv_idx, cand;
    logic            adv_found;
    logic            frame_manual, frame_manual_next;
    logic [63:0]     shift_reg, shift_next, pattern;
    logic [5:0]      bit_cnt, bit_cnt_next;
    logic [7:0]      phase_cnt, phase_cnt_next;
    logic            phase_hi, phase_hi_next;
    logic            s_clk_next, s_clrn_next, sout_next, seg_en_next;
    logic            busy_next, frame_done_next;
    logic [1:0]      cur_idx_next, load_idx;
    logic [31:0]     load_value;

    assign tick          = (refresh_cnt == REFRESH_LAST);
    assign load_idx      = manual ? sel_idx : auto_idx;
    assign load_value    = src_valid[load_idx] ? src_data[load_idx] : 32'h0;
    assign frame_cnt_inc = frame_cnt + 1'b1;

    for (genvar k = 0; k < 8; k++) begin : g_digit
        seg7_nibble_enc u_enc (
            .nibble (load_value[4*k+3:4*k]),
            .dp_on  ({1'b0, load_idx} == 3'(k)),
            .seg    (pattern[8*k+7:8*k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || tick) refresh_cnt <= '0;
        else             refresh_cnt <= refresh_cnt + 1'b1;
    end

    // Next valid source after the current one, wrapping back to itself.
    always_comb begin
        adv_idx   = auto_idx;
        adv_found = 1'b0;
        cand      = auto_idx;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = auto_idx + 2'(i);
            if (!adv_found && src_valid[cand]) begin
                adv_idx   = cand;
                adv_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Output registers are loaded with the values of the state being entered,
    // so every output lines up with the state register cycle by cycle.
    always_comb begin
        state_next        = state;
        frame_cnt_next    = frame_cnt;
        auto_idx_next     = auto_idx;
        frame_manual_next = frame_manual;
        shift_next        = shift_reg;
        bit_cnt_next      = bit_cnt;
        phase_cnt_next    = phase_cnt;
        phase_hi_next     = phase_hi;
        s_clk_next        = 1'b0;
        s_clrn_next       = 1'b1;
        sout_next         = sout;
        seg_en_next       = seg_en;
        cur_idx_next      = cur_idx;
        busy_next         = 1'b0;
        frame_done_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_next  = ST_LOAD;
                    s_clrn_next = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            ST_LOAD: begin
                state_next        = ST_SHIFT;
                busy_next         = 1'b1;
                cur_idx_next      = load_idx;
                frame_manual_next = manual;
                sout_next         = pattern[63];
                shift_next        = {pattern[62:0], 1'b0};
                bit_cnt_next      = 6'd63;
                phase_cnt_next    = 8'd0;
                phase_hi_next     = 1'b0;
            end
            ST_SHIFT: begin
                busy_next = 1'b1;
                if (phase_cnt == DIV_LAST) begin
                    phase_cnt_next = 8'd0;
                    if (!phase_hi) begin
                        phase_hi_next = 1'b1;
                        s_clk_next    = 1'b1;
                    end else begin
                        phase_hi_next = 1'b0;
                        if (bit_cnt == 6'd0) begin
                            state_next      = ST_DONE;
                            frame_done_next = 1'b1;
                            seg_en_next     = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt - 1'b1;
                            sout_next    = shift_reg[63];
                            shift_next   = {shift_reg[62:0], 1'b0};
                        end
                    end
                end else begin
                    phase_cnt_next = phase_cnt + 1'b1;
                    s_clk_next     = phase_hi;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                if (frame_manual) begin
                    frame_cnt_next = '0;
                end else if (frame_cnt_inc == DWELL_LAST) begin
                    frame_cnt_next = '0;
                    auto_idx_next  = adv_idx;
                end else begin
                    frame_cnt_next = frame_cnt_inc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt    <= '0;
            auto_idx     <= 2'd0;
            frame_manual <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= 6'd0;
            phase_cnt    <= 8'd0;
            phase_hi     <= 1'b0;
            s_clk        <= 1'b0;
            s_clrn       <= 1'b0;
            sout         <= 1'b0;
            seg_en       <= 1'b0;
            cur_idx      <= 2'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_cnt    <= frame_cnt_next;
            auto_idx     <= auto_idx_next;
            frame_manual <= frame_manual_next;
            shift_reg    <= shift_next;
            bit_cnt      <= bit_cnt_next;
            phase_cnt    <= phase_cnt_next;
            phase_hi     <= phase_hi_next;
            s_clk        <= s_clk_next;
            s_clrn       <= s_clrn_next;
            sout         <= sout_next;
            seg_en       <= seg_en_next;
            cur_idx      <= cur_idx_next;
            busy         <= busy_next;
            frame_done   <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues hand-computed frame
// patterns, a monitor reassembles each shifted frame and checks it and its timing.
module tb_seg_scan_ctrl;

    typedef struct {
        logic [63:0] pattern;
        logic [1:0]  idx;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        src_valid = 4'b0;
    logic [3:0][31:0]  src_data = '0;
    logic              manual = 1'b0;
    logic [1:0]        sel_idx = 2'd0;
    logic              s_clk, s_clrn, sout, seg_en, busy, frame_done;
    logic [1:0]        cur_idx;

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    frame_t      exp_q[$];
    logic [63:0] last_pattern = '0;

    seg_scan_ctrl #(
        .CLK_DIV        (2),
        .REFRESH_CYCLES (300),
        .DWELL_FRAMES   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .manual     (manual),
        .sel_idx    (sel_idx),
        .s_clk      (s_clk),
        .s_clrn     (s_clrn),
        .sout       (sout),
        .seg_en     (seg_en),
        .cur_idx    (cur_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic man, input logic [1:0] sel,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3);
        src_valid   = valid;
        manual      = man;
        sel_idx     = sel;
        src_data[0] = d0;
        src_data[1] = d1;
        src_data[2] = d2;
        src_data[3] = d3;
    endtask

    task automatic pushFrame(input logic [63:0] pattern, input logic [1:0] idx);
        frame_t f;
        f.pattern = pattern;
        f.idx     = idx;
        exp_q.push_back(f);
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_count < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_timeout: got %0d frames, expected %0d", done_count, target);
        end
    endtask

    task automatic waitFrameStart(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL start_timeout: busy %b after %0d cycles, expected 1", busy, n);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_clk"}, 64'(s_clk), 64'd0);
        checkOutput({tag, "_s_clrn"}, 64'(s_clrn), 64'd0);
        checkOutput({tag, "_sout"}, 64'(sout), 64'd0);
        checkOutput({tag, "_seg_en"}, 64'(seg_en), 64'd0);
        checkOutput({tag, "_cur_idx"}, 64'(cur_idx), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    // Monitor: samples 2 time units after each rising edge, rebuilds the bitstream
    // from s_clk rising edges and scores every completed frame.
    logic [63:0] cap = '0;
    int          nbits = 0, busy_cnt = 0, viol = 0, run_len = 0, clrn_lows = 0;
    logic        prev_clk = 1'b0, prev_sout = 1'b0, rst_q = 1'b1;
    logic        in_shift;
    frame_t      exp_f;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            nbits = 0; busy_cnt = 0; viol = 0; run_len = 0; clrn_lows = 0;
        end else begin
            if (!s_clrn && !rst_q) clrn_lows++;
            if (busy) busy_cnt++;
            if (busy && !s_clrn) begin
                cap = '0; nbits = 0; busy_cnt = 1; viol = 0; run_len = 0;
            end
            in_shift = busy && s_clrn && !frame_done;
            if (in_shift) begin
                if (run_len != 0 && s_clk == prev_clk) begin
                    run_len++;
                end else begin
                    if (run_len != 0 && run_len != 2) viol++;
                    run_len = 1;
                end
                if (s_clk && prev_clk && sout != prev_sout) viol++;
                if (s_clk && !prev_clk) begin
                    cap = {cap[62:0], sout};
                    nbits++;
                end
            end
            if (frame_done) begin
                if (run_len != 2) viol++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: got frame_done with pattern %h, expected none", cap);
                end else begin
                    exp_f = exp_q.pop_front();
                    checkOutput($sformatf("f%0d_pattern", done_count), cap, exp_f.pattern);
                    checkOutput($sformatf("f%0d_cur_idx", done_count), 64'(cur_idx), 64'(exp_f.idx));
                    checkOutput($sformatf("f%0d_nbits", done_count), 64'(nbits), 64'd64);
                    checkOutput($sformatf("f%0d_length", done_count), 64'(busy_cnt), 64'd258);
                    checkOutput($sformatf("f%0d_timing_viol", done_count), 64'(viol), 64'd0);
                    checkOutput($sformatf("f%0d_clrn_lows", done_count), 64'(clrn_lows), 64'd1);
                end
                last_pattern = cap;
                clrn_lows    = 0;
                done_count++;
            end
        end
        prev_clk  = s_clk;
        prev_sout = sout;
        rst_q     = rst;
    end

    initial begin
        int          n;
        logic        seg_seen;
        logic [7:0]  first_byte, last_byte;

        // Power-on reset, then a single valid source showing 8000_0000.
        applyStimulus(4'b0001, 1'b0, 2'd0, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rst = 1'b0;
        pushFrame(64'h80C0C0C0_C0C0C040, 2'd0);
        waitFrames(1, 700);
        first_byte = last_pattern[63:56];
        last_byte  = last_pattern[7:0];
        checkOutput("first_byte", 64'(first_byte), 64'h80);
        checkOutput("last_byte", 64'(last_byte), 64'h40);
        checkOutput("seg_en_at_done", 64'(seg_en), 64'd1);
        repeat (10) @(negedge clk);
        checkOutput("seg_en_held", 64'(seg_en), 64'd1);

        // Auto round-robin over sources 1 and 3, two frames each.
        rst = 1'b1;
        applyStimulus(4'b1010, 1'b0, 2'd0, 32'h8888_8888, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pushFrame(64'hC0C0C0C0_C0C0C040, 2'd0);
        pushFrame(64'hC0C0C0C0_C0C0C040, 2'd0);
        pushFrame(64'hC0C0C0C0_C0C040C0, 2'd1);
        pushFrame(64'hC0C0C0C0_C0C040C0, 2'd1);
        pushFrame(64'hC0C0C0C0_40C0C0C0, 2'd3);
        pushFrame(64'hC0C0C0C0_40C0C0C0, 2'd3);
        pushFrame(64'hC0C0C0C0_C0C040C0, 2'd1);
        waitFrames(8, 2600);

        // Manual source 2; inputs change mid-shift and only the next frame sees them.
        applyStimulus(4'b1111, 1'b1, 2'd2, 32'h0, 32'h0, 32'h1234_ABCD, 32'h0);
        pushFrame(64'hF9A4B099_8803C6A1, 2'd2);
        waitFrameStart(400);
        repeat (50) @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 2'd1, 32'h0, 32'h0000_0008, 32'h8888_8888, 32'h0);
        pushFrame(64'hC0C0C0C0_C0C04080, 2'd1);
        waitFrames(10, 800);
        sel_idx = 2'd2;
        pushFrame(64'h80808080_80008080, 2'd2);
        waitFrames(11, 400);

        // One-cycle reset around bit 30 of a frame aborts it silently.
        waitFrameStart(400);
        repeat (133) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("mid");
        pushFrame(64'h80808080_80008080, 2'd2);
        n = 0;
        seg_seen = 1'b0;
        while (!busy && n < 400) begin
            @(negedge clk);
            n++;
            if (seg_en) seg_seen = 1'b1;
        end
        checkOutput("restart_delay", 64'(n), 64'd300);
        checkOutput("seg_en_after_abort", 64'(seg_seen), 64'd0);
        waitFrames(12, 400);
        checkOutput("seg_en_after_restart", 64'(seg_en), 64'd1);

        repeat (5) @(negedge clk);
        checkOutput("pending_frames", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
